// File: rtl/euler_step_unit.sv
// Sequential fixed-point Euler integrator for one body axis: vel' = vel + acc*dt,
// then pos' = pos + vel'*dt, sharing one sign-magnitude multiplier across two cycles.
module euler_step_unit #(
  parameter int WIDTH = 32,
  parameter int Q     = 16
) (
  input  logic             clock,
  input  logic             reset_L,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] pos_in,
  input  logic [WIDTH-1:0] vel_in,
  input  logic [WIDTH-1:0] acc_in,
  input  logic [WIDTH-1:0] dt_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] pos_out,
  output logic [WIDTH-1:0] vel_out,
  output logic             ovf,
  output logic [1:0]       dbg_state
);

  // Handshake: a transfer happens on a rising clock edge where valid and ready are
  // both high; in_valid is only looked at in IDLE and out_valid holds until out_ready.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUL_V = 2'd1,
    MUL_P = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] pos_l, vel_l, acc_l, dt_l;
  logic [WIDTH-1:0] pos_r, vel_r;
  logic             ovf_r;

  logic [WIDTH-1:0]   mul_a, mag_a, mag_b;
  logic               mul_neg;
  logic [2*WIDTH-1:0] mag_p, mag_shift;
  logic [WIDTH-1:0]   trunc_kept, trunc_val;
  logic               trunc_ovf;

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = MUL_V;
      end
      MUL_V: state_nx = MUL_P;
      MUL_P: state_nx = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // MUL_P multiplies by the velocity written in MUL_V, not the latched input.
  always_comb begin
    mul_a      = (state == MUL_P) ? vel_r : acc_l;
    mag_a      = mul_a[WIDTH-1] ? -mul_a : mul_a;
    mag_b      = dt_l[WIDTH-1] ? -dt_l : dt_l;
    mul_neg    = mul_a[WIDTH-1] ^ dt_l[WIDTH-1];
    mag_p      = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
    mag_shift  = mag_p >> Q;
    trunc_kept = {1'b0, mag_shift[WIDTH-2:0]};
    trunc_val  = mul_neg ? -trunc_kept : trunc_kept;
    trunc_ovf  = |mag_shift[2*WIDTH-1:WIDTH-1];
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state <= IDLE;
      pos_l <= '0;
      vel_l <= '0;
      acc_l <= '0;
      dt_l  <= '0;
      pos_r <= '0;
      vel_r <= '0;
      ovf_r <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (in_valid) begin
            pos_l <= pos_in;
            vel_l <= vel_in;
            acc_l <= acc_in;
            dt_l  <= dt_in;
            ovf_r <= 1'b0;
          end
        end
        MUL_V: begin
          vel_r <= vel_l + trunc_val;
          if (trunc_ovf) ovf_r <= 1'b1;
        end
        MUL_P: begin
          pos_r <= pos_l + trunc_val;
          if (trunc_ovf) ovf_r <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign pos_out   = pos_r;
  assign vel_out   = vel_r;
  assign ovf       = ovf_r;
  assign dbg_state = state;

endmodule

// File: tb/tb_euler_step_unit.sv
// Bench for euler_step_unit: directed vector table, backpressure and reset corner
// cases, then random steps against an arithmetic reference model.
module tb_euler_step_unit;

  localparam int W = 32;
  localparam int Q = 16;

  logic         clock;
  logic         reset_L;
  logic         in_valid, in_ready;
  logic [W-1:0] pos_in, vel_in, acc_in, dt_in;
  logic         out_valid, out_ready;
  logic [W-1:0] pos_out, vel_out;
  logic         ovf;
  logic [1:0]   dbg_state;

  int checks   = 0;
  int failures = 0;

  euler_step_unit #(.WIDTH(W), .Q(Q)) dut (
    .clock     (clock),
    .reset_L   (reset_L),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pos_in    (pos_in),
    .vel_in    (vel_in),
    .acc_in    (acc_in),
    .dt_in     (dt_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pos_out   (pos_out),
    .vel_out   (vel_out),
    .ovf       (ovf),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [W-1:0] pos, vel, acc, dt;
    logic [W-1:0] exp_pos, exp_vel;
    logic         exp_ovf;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: signed product, magnitude truncated toward zero to W-1 bits.
  function automatic logic [W:0] ref_trunc(input logic [W-1:0] a, input logic [W-1:0] b);
    longint     p;
    logic [63:0] m, kept, r;
    logic       o;
    p    = longint'($signed(a)) * longint'($signed(b));
    m    = (p < 0) ? 64'(-p) : 64'(p);
    o    = ((m >> (W + Q - 1)) != 0);
    kept = (m >> Q) & ((64'd1 << (W - 1)) - 64'd1);
    r    = (p < 0) ? -kept : kept;
    return {o, r[W-1:0]};
  endfunction

  task automatic ref_step(input logic [W-1:0] p, v, a, d,
                          output logic [W-1:0] ep, ev, output logic eo);
    logic [W:0] t1, t2;
    t1 = ref_trunc(a, d);
    ev = v + t1[W-1:0];
    t2 = ref_trunc(ev, d);
    ep = p + t2[W-1:0];
    eo = t1[W] | t2[W];
  endtask

  // Driver: one full step with `hold` cycles of backpressure in DONE.
  task automatic do_step(input logic [W-1:0] p, v, a, d, input int hold,
                         output logic [W-1:0] rp, rv, output logic ro);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin @(posedge clock); #1; n++; end
    check("in_ready_before_accept", 64'(in_ready), 64'd1);
    pos_in = p; vel_in = v; acc_in = a; dt_in = d; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    pos_in = $urandom; vel_in = $urandom; acc_in = $urandom; dt_in = $urandom;
    n = 0;
    while (!out_valid && n < 20) begin @(posedge clock); #1; n++; end
    check("latency_edges_after_accept", 64'(n), 64'd2);
    rp = pos_out; rv = vel_out; ro = ovf;
    for (int i = 0; i < hold; i++) begin
      @(posedge clock); #1;
      check("valid_held", 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    check("valid_drops_after_take", 64'(out_valid), 64'd0);
    check("ready_after_take", 64'(in_ready), 64'd1);
  endtask

  function automatic logic [W-1:0] rand_val();
    case ($urandom_range(0, 4))
      0: return $urandom;
      1: return W'($signed($urandom_range(0, 1 << 21)) - (1 << 20));
      2: return 32'h8000_0000;
      3: return W'($urandom_range(0, 1 << 18));
      default: return 32'h0;
    endcase
  endfunction

  initial begin
    logic [W-1:0] gp, gv, ep, ev, hp, hv;
    logic         go, eo, ho;

    vecs[0] = '{32'h0, 32'h0001_0000, 32'h0002_0000, 32'h0000_8000, 32'h0001_0000, 32'h0002_0000, 1'b0};
    vecs[1] = '{32'h0, 32'h0, 32'hFFFE_0000, 32'h0000_8000, 32'hFFFF_8000, 32'hFFFF_0000, 1'b0};
    vecs[2] = '{32'h0005_0000, 32'h0, 32'hFFFF_FFFF, 32'h0000_8000, 32'h0005_0000, 32'h0, 1'b0};
    vecs[3] = '{32'h0, 32'h0001_0000, 32'h4000_0000, 32'h0004_0000, 32'h0004_0000, 32'h0001_0000, 1'b1};
    vecs[4] = '{32'h0, 32'h0, 32'h8000_0000, 32'h0001_0000, 32'h0, 32'h0, 1'b1};
    vecs[5] = '{32'h0, 32'h7FFF_FFFF, 32'h0001_0000, 32'h0001_0000, 32'h8000_FFFF, 32'h8000_FFFF, 1'b0};

    reset_L = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    pos_in = '0; vel_in = '0; acc_in = '0; dt_in = '0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_pos_out", 64'(pos_out), 64'd0);
    check("reset_vel_out", 64'(vel_out), 64'd0);
    check("reset_ovf", 64'(ovf), 64'd0);
    check("reset_state", 64'(dbg_state), 64'd0);
    reset_L = 1'b1;
    @(posedge clock); #1;

    // Directed table
    for (int i = 0; i < 6; i++) begin
      do_step(vecs[i].pos, vecs[i].vel, vecs[i].acc, vecs[i].dt, i % 3, gp, gv, go);
      check($sformatf("vec%0d_vel", i), 64'(gv), 64'(vecs[i].exp_vel));
      check($sformatf("vec%0d_pos", i), 64'(gp), 64'(vecs[i].exp_pos));
      check($sformatf("vec%0d_ovf", i), 64'(go), 64'(vecs[i].exp_ovf));
      check($sformatf("vec%0d_idle_hold_vel", i), 64'(vel_out), 64'(vecs[i].exp_vel));
    end

    // Backpressure: hold off in DONE with in_valid noise (overflow step so ovf=1 is held)
    pos_in = vecs[3].pos; vel_in = vecs[3].vel; acc_in = vecs[3].acc; dt_in = vecs[3].dt;
    in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("bp_reach_done", 64'(out_valid), 64'd1);
    hp = pos_out; hv = vel_out; ho = ovf;
    check("bp_ovf_value", 64'(ho), 64'd1);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      pos_in = $urandom; vel_in = $urandom; acc_in = $urandom; dt_in = $urandom;
      @(posedge clock); #1;
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_pos_stable", 64'(pos_out), 64'(hp));
      check("bp_vel_stable", 64'(vel_out), 64'(hv));
      check("bp_ovf_stable", 64'(ovf), 64'(ho));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    check("bp_release_in_ready", 64'(in_ready), 64'd1);
    check("bp_release_out_valid", 64'(out_valid), 64'd0);
    @(posedge clock); #1;
    check("bp_no_phantom_step", 64'(in_ready), 64'd1);

    // Reset mid-step (in MUL_P)
    pos_in = vecs[0].pos; vel_in = vecs[0].vel; acc_in = vecs[0].acc; dt_in = vecs[0].dt;
    in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    @(posedge clock); #1;
    check("rst_mid_state_mul_p", 64'(dbg_state), 64'd2);
    reset_L = 1'b0;
    #1;
    check("rst_mid_out_valid", 64'(out_valid), 64'd0);
    check("rst_mid_in_ready", 64'(in_ready), 64'd1);
    check("rst_mid_pos_out", 64'(pos_out), 64'd0);
    check("rst_mid_vel_out", 64'(vel_out), 64'd0);
    check("rst_mid_ovf", 64'(ovf), 64'd0);
    @(posedge clock); #1;
    reset_L = 1'b1;
    do_step(vecs[0].pos, vecs[0].vel, vecs[0].acc, vecs[0].dt, 0, gp, gv, go);
    check("rst_after_vel", 64'(gv), 64'h0002_0000);
    check("rst_after_pos", 64'(gp), 64'h0001_0000);
    check("rst_after_ovf", 64'(go), 64'd0);

    // Random steps against the reference model
    for (int i = 0; i < 150; i++) begin
      logic [W-1:0] rp, rv, ra, rd;
      rp = rand_val(); rv = rand_val(); ra = rand_val(); rd = rand_val();
      ref_step(rp, rv, ra, rd, ep, ev, eo);
      do_step(rp, rv, ra, rd, $urandom_range(0, 3), gp, gv, go);
      check("rand_vel", 64'(gv), 64'(ev));
      check("rand_pos", 64'(gp), 64'(ep));
      check("rand_ovf", 64'(go), 64'(eo));
      repeat ($urandom_range(0, 2)) @(posedge clock);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
